// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - parametrised single-clock FIFO with count, programmable flags and error pulses
// Optional first-word-fall-through read mode selected by defining FIFO_FWFT_EN.
module fifo_sync_param #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 1
) (
    input  logic              clk_w,
    input  logic              reset,
    input  logic              wre,
    input  logic [DATA_W-1:0] wrd,
    input  logic              rde,
    output logic [DATA_W-1:0] rdd,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] AF_CNT  = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_CNT  = (ADDR_W+1)'(AE_LEVEL);
    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic              rd_ok;
    logic              wr_ok;

    // Pointers carry one extra wrap bit, so their difference is the occupancy.
    assign count        = wr_ptr - rd_ptr;
    assign empty        = (wr_ptr == rd_ptr);
    assign full         = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                          (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);

    // A pop frees a slot in the same edge, so a full FIFO still accepts a write.
    assign rd_ok = rde && !empty;
    assign wr_ok = wre && (!full || rd_ok);

    always_ff @(posedge clk_w or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
            overflow  <= wre && !wr_ok;
            underflow <= rde && !rd_ok;
        end
    end

    always_ff @(posedge clk_w) begin
        if (wr_ok) mem[wr_ptr[ADDR_W-1:0]] <= wrd;
    end

`ifdef FIFO_FWFT_EN
    assign rdd = empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];
`else
    logic [DATA_W-1:0] rdd_q;

    always_ff @(posedge clk_w or negedge reset) begin
        if (!reset) begin
            rdd_q <= '0;
        end else if (rd_ok) begin
            rdd_q <= mem[rd_ptr[ADDR_W-1:0]];
        end
    end

    assign rdd = rdd_q;
`endif

endmodule
